// File: rtl/reg_bank_rotator_pkg.sv
// Shared types for the reorderable register bank: command codes, FSM states
// and rotate direction constants.
package reg_bank_rotator_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_SWAP  = 3'd2,
    OP_ROTL  = 3'd3,
    OP_ROTR  = 3'd4,
    OP_CLEAR = 3'd5
  } op_code_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ROT  = 1'b1
  } state_e;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

endpackage

// File: rtl/reg_bank_rotator.sv
// Small register file of NUM_REGS x WIDTH with load/swap/clear and
// multi-cycle rotate (one position per clock) behind a valid/ready handshake.
module reg_bank_rotator
  import reg_bank_rotator_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [2:0]                op_code,
  input  logic [IDX_W-1:0]          idx_a,
  input  logic [IDX_W-1:0]          idx_b,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [IDX_W-1:0]          amount,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic [WIDTH-1:0]          rd_data,
  output logic [NUM_REGS*WIDTH-1:0] regs_flat,
  output logic                      done,
  output logic                      err
);

  logic [WIDTH-1:0] regs  [NUM_REGS];
  logic [WIDTH-1:0] rot_l [NUM_REGS];
  logic [WIDTH-1:0] rot_r [NUM_REGS];
  state_e           state;
  logic             dir;
  logic [IDX_W-1:0] cnt;
  logic             a_ok, b_ok, rd_ok;

  // Index range checks only matter when NUM_REGS is not a power of two
  if ((2 ** IDX_W) == NUM_REGS) begin : g_full_range
    assign a_ok  = 1'b1;
    assign b_ok  = 1'b1;
    assign rd_ok = 1'b1;
  end else begin : g_partial_range
    assign a_ok  = 32'(idx_a)  < NUM_REGS;
    assign b_ok  = 32'(idx_b)  < NUM_REGS;
    assign rd_ok = 32'(rd_idx) < NUM_REGS;
  end

  // One-position rotated views of the bank
  always_comb begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      rot_l[i] = regs[IDX_W'((i + int'(NUM_REGS) - 1) % int'(NUM_REGS))];
      rot_r[i] = regs[IDX_W'((i + 1) % int'(NUM_REGS))];
    end
  end

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = regs[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs     <= '{default: '0};
      state    <= ST_IDLE;
      op_ready <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_data  <= '0;
      cnt      <= '0;
      dir      <= DIR_L;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      rd_data <= rd_ok ? regs[rd_idx] : '0;

      unique case (state)
        ST_IDLE: begin
          if (op_valid) begin
            case (op_code_e'(op_code))
              OP_NOP: done <= 1'b1;
              OP_LOAD: begin
                if (a_ok) begin
                  regs[idx_a] <= wr_data;
                  done        <= 1'b1;
                end else begin
                  err <= 1'b1;
                end
              end
              OP_SWAP: begin
                if (a_ok && b_ok) begin
                  regs[idx_a] <= regs[idx_b];
                  regs[idx_b] <= regs[idx_a];
                  done        <= 1'b1;
                end else begin
                  err <= 1'b1;
                end
              end
              OP_ROTL, OP_ROTR: begin
                if (amount == '0) begin
                  done <= 1'b1;
                end else begin
                  // Accept edge performs the first step
                  if (op_code_e'(op_code) == OP_ROTL) begin
                    regs <= rot_l;
                    dir  <= DIR_L;
                  end else begin
                    regs <= rot_r;
                    dir  <= DIR_R;
                  end
                  cnt <= amount - IDX_W'(1);
                  if (amount == IDX_W'(1)) begin
                    done <= 1'b1;
                  end else begin
                    state    <= ST_ROT;
                    op_ready <= 1'b0;
                  end
                end
              end
              OP_CLEAR: begin
                regs <= '{default: '0};
                done <= 1'b1;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        ST_ROT: begin
          if (dir == DIR_L) regs <= rot_l;
          else              regs <= rot_r;
          cnt <= cnt - IDX_W'(1);
          if (cnt == IDX_W'(1)) begin
            state    <= ST_IDLE;
            op_ready <= 1'b1;
            done     <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_rotator.sv
// Scoreboard bench for reg_bank_rotator: default 4x8 instance under directed
// and random commands, plus a 3x4 instance for out-of-range index handling.
module tb_reg_bank_rotator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_code  = '0;
  logic [1:0]  idx_a    = '0;
  logic [1:0]  idx_b    = '0;
  logic [7:0]  wr_data  = '0;
  logic [1:0]  amount   = '0;
  logic [1:0]  rd_idx   = '0;
  logic [7:0]  rd_data;
  logic [31:0] regs_flat;
  logic        done, err;

  logic        v1 = 1'b0;
  logic        rdy1;
  logic [2:0]  oc1 = '0;
  logic [1:0]  a1 = '0, b1 = '0, amt1 = '0, rdi1 = '0;
  logic [3:0]  wd1 = '0;
  logic [3:0]  rd1;
  logic [11:0] flat1;
  logic        done1, err1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic        is_err;
    logic [31:0] flat;
  } exp_t;
  exp_t sb[$];

  int unsigned m[4];

  always #5 clk = ~clk;

  reg_bank_rotator dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .idx_a(idx_a), .idx_b(idx_b), .wr_data(wr_data),
    .amount(amount), .rd_idx(rd_idx), .rd_data(rd_data),
    .regs_flat(regs_flat), .done(done), .err(err)
  );

  reg_bank_rotator #(.WIDTH(4), .NUM_REGS(3)) dut3 (
    .clk(clk), .rst(rst), .op_valid(v1), .op_ready(rdy1),
    .op_code(oc1), .idx_a(a1), .idx_b(b1), .wr_data(wd1),
    .amount(amt1), .rd_idx(rdi1), .rd_data(rd1),
    .regs_flat(flat1), .done(done1), .err(err1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] mflat();
    logic [31:0] f;
    for (int i = 0; i < 4; i++) f[i*8 +: 8] = m[i][7:0];
    return f;
  endfunction

  // Reference: rotating by k moves the value at position i to i+k (left) or i-k (right)
  task automatic model(input int op, input int a, input int b, input int d, input int amt,
                       output bit e);
    int unsigned o[4];
    int unsigned t;
    e = 1'b0;
    o = m;
    case (op)
      0: ;
      1: if (a < 4) m[a] = d & 8'hFF; else e = 1'b1;
      2: if (a < 4 && b < 4) begin t = m[a]; m[a] = m[b]; m[b] = t; end else e = 1'b1;
      3: for (int i = 0; i < 4; i++) m[(i + amt) % 4] = o[i];
      4: for (int i = 0; i < 4; i++) m[i] = o[(i + amt) % 4];
      5: for (int i = 0; i < 4; i++) m[i] = 0;
      default: e = 1'b1;
    endcase
  endtask

  // Caller is at a negedge; returns at the negedge where the response is visible
  task automatic issue(input int op, input int a, input int b, input int d, input int amt);
    int unsigned exp_rd;
    bit e;
    int lowc;
    int r;
    r      = int'($urandom_range(0, 3));
    rd_idx = 2'(r);
    exp_rd = m[r];
    check("ready_before_cmd", 64'(op_ready), 64'd1);
    op_valid = 1'b1;
    op_code  = 3'(op);
    idx_a    = 2'(a);
    idx_b    = 2'(b);
    wr_data  = 8'(d);
    amount   = 2'(amt);
    model(op, a, b, d, amt, e);
    sb.push_back('{is_err: e, flat: mflat()});
    @(negedge clk);
    op_valid = 1'b0;
    if ((op == 3 || op == 4) && amt > 1) begin
      lowc = 0;
      while (!op_ready && lowc < 20) begin
        lowc++;
        @(negedge clk);
      end
      check("ready_low_cycles", 64'(lowc), 64'(amt - 1));
    end else begin
      check("rd_data", 64'(rd_data), 64'(exp_rd & 8'hFF));
    end
  endtask

  // Monitor: every done/err pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t ex;
    if (!rst && (done || err)) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse done=%0b err=%0b required no pulse", done, err);
      end else begin
        ex = sb.pop_front();
        check("resp_done", 64'(done), 64'(!ex.is_err));
        check("resp_err", 64'(err), 64'(ex.is_err));
        check("resp_flat", 64'(regs_flat), 64'(ex.flat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) m[i] = 0;
    repeat (3) @(negedge clk);
    check("reset_flat", 64'(regs_flat), 64'd0);
    check("reset_rd", 64'(rd_data), 64'd0);
    check("reset_done_err", 64'({done, err}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(op_ready), 64'd1);

    // Back-to-back loads
    issue(1, 0, 0, 8'h11, 0);
    issue(1, 1, 0, 8'h22, 0);
    issue(1, 2, 0, 8'h33, 0);
    issue(1, 3, 0, 8'h44, 0);
    check("load_flat", 64'(regs_flat), 64'h44332211);

    issue(2, 0, 3, 0, 0);
    check("swap_flat", 64'(regs_flat), 64'h11332244);
    issue(2, 2, 2, 0, 0);
    check("swap_same_flat", 64'(regs_flat), 64'h11332244);
    issue(2, 3, 0, 0, 0);

    issue(3, 0, 0, 0, 3);
    issue(4, 0, 0, 0, 1);
    issue(3, 0, 0, 0, 0);
    check("rot_zero_ready", 64'(op_ready), 64'd1);
    issue(7, 1, 2, 8'h5A, 0);
    issue(6, 0, 0, 0, 0);
    issue(5, 0, 0, 0, 0);
    check("clear_flat", 64'(regs_flat), 64'd0);

    for (int n = 0; n < 150; n++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 3)));
    end

    // Non-power-of-two bank: out-of-range index rejected, reads of it give 0
    oc1 = 3'd1; a1 = 2'd3; wd1 = 4'h5; v1 = 1'b1; rdi1 = 2'd3;
    @(negedge clk);
    v1 = 1'b0;
    check("n3_err", 64'({err1, done1}), 64'b10);
    check("n3_flat_unchanged", 64'(flat1), 64'd0);
    check("n3_rd_oob", 64'(rd1), 64'd0);
    oc1 = 3'd1; a1 = 2'd1; wd1 = 4'hA; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0; rdi1 = 2'd1;
    check("n3_load_done", 64'({err1, done1}), 64'b01);
    @(negedge clk);
    check("n3_rd_data", 64'(rd1), 64'hA);
    check("n3_flat", 64'(flat1), 64'h0A0);

    // Reset in the middle of a rotate
    op_valid = 1'b1; op_code = 3'd4; amount = 2'd3;
    @(negedge clk);
    op_valid = 1'b0;
    check("rot_busy", 64'(op_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("async_reset_flat", 64'(regs_flat), 64'd0);
    check("async_reset_ready", 64'(op_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m[i] = 0;
    repeat (5) @(negedge clk);
    check("post_reset_flat", 64'(regs_flat), 64'd0);
    check("post_reset_ready", 64'(op_ready), 64'd1);
    issue(1, 2, 0, 8'hC3, 0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
